mac_seq_ctrl: RTL

Sequencing controller for the team's combinational 4-bit multiply-accumulate datapath (`MAC_4bit`: `a`, `b`, `c[11:0]` in; `result[11:0]`, `cout` out). It accepts a stream of 4-bit operand pairs over a valid/ready handshake and feeds each pair through one internal `MAC_4bit` instance, with a 12-bit accumulator register closing the loop on `c`. After `LEN` pairs it presents the dot product and a sticky overflow flag on an output handshake. It is the building block for vector dot-product units in the AI-chip datapath.

---
 rtl/mac_seq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl -- sequencing controller around a combinational 4-bit MAC.
//
// Accepts LEN unsigned 4-bit operand pairs over a valid/ready handshake.
// It folds each pair into a 12-bit accumulator through one MAC_4bit
// instance: acc <= acc + a*b, modulo 4096. It then presents the dot product
// and a sticky overflow flag on an output valid/ready handshake.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, init[11:0]  begin an operation (IDLE only), initial accumulator
//   abort              cancel an operation in ACCUM or DONE
//   in_valid/in_ready  operand handshake, in_a/in_b operands
//   out_valid/out_ready result handshake, out_result/out_ovf result
//   busy               state is not IDLE
//   count[CW-1:0]      pairs accepted in the current operation
//
// MAC_4bit is the team's combinational multiply-accumulate datapath:
// result = c + a*b (mod 4096), cout = carry out of that 12-bit add.

module MAC_4bit (
   input  logic [3:0]  a,
   input  logic [3:0]  b,
   input  logic [11:0] c,
   output logic [11:0] result,
   output logic        cout
);

   logic [7:0]  prod;
   logic [12:0] sum;

   assign prod   = a * b;
   assign sum    = {1'b0, c} + {5'b0, prod};
   assign result = sum[11:0];
   assign cout   = sum[12];

endmodule

module mac_seq_ctrl #(
   parameter int LEN = 4,
   parameter int CW  = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [11:0]   init,
   input  logic          abort,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_a,
   input  logic [3:0]    in_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [11:0]   out_result,
   output logic          out_ovf,
   output logic          busy,
   output logic [CW-1:0] count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   state_t      state;
   logic [11:0] acc;
   logic        ovf;
   logic [11:0] mac_result;
   logic        mac_cout;

   // Operands go straight into the MAC. The accumulator closes the loop on c.
   MAC_4bit u_mac (
      .a      (in_a),
      .b      (in_b),
      .c      (acc),
      .result (mac_result),
      .cout   (mac_cout)
   );

   // The handshake outputs are registered copies of the state decode. They
   // change on the same edge as the state, so in_ready never looks at
   // in_valid and out_valid depends only on state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= 12'd0;
         ovf       <= 1'b0;
         count     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc      <= init;
                  ovf      <= 1'b0;
                  count    <= '0;
                  state    <= ACCUM;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end

            ACCUM: begin
               // abort wins over a beat arriving in the same cycle.
               if (abort) begin
                  state    <= IDLE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
               end else if (in_valid) begin
                  acc   <= mac_result;
                  ovf   <= ovf | mac_cout;
                  count <= count + CW'(1);
                  if (count == LAST) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end

            DONE: begin
               // acc/ovf/count stay put so the result is stable until taken
               // and remains readable after returning to IDLE.
               if (abort || out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_result = acc;
   assign out_ovf    = ovf;

endmodule
